// File: rtl/fifo_nibble_packer_pkg.sv
// Shared definitions for the nibble packer: state encodings, data widths and
// the helper that orders two nibbles into an output byte.
package fifo_nibble_packer_pkg;

    localparam int NIB_W  = 4;
    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_HALF  = 2'd1,
        ST_BYTE  = 2'd2
    } state_t;

    // first = nibble popped earlier, second = nibble popped later (or zero pad).
    function automatic logic [BYTE_W-1:0] pack_nibbles(
        input logic [NIB_W-1:0] first,
        input logic [NIB_W-1:0] second,
        input bit               lsn_first
    );
        return lsn_first ? {second, first} : {first, second};
    endfunction

endpackage

// File: rtl/fifo_nibble_packer_timeout_ctr.sv
// nibble_timeout_ctr: saturating idle counter for the packer's HALF state.
// Ports:
//   clk     - read-domain clock
//   rst     - asynchronous active-low reset
//   clear   - synchronous clear (has priority over enable)
//   enable  - count one idle cycle
//   expired - counter has reached TIMEOUT-1 (never asserted when TIMEOUT=0)
module nibble_timeout_ctr #(
    parameter int unsigned TIMEOUT = 0,
    parameter int unsigned TO_W    = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [TO_W-1:0] EXPIRE_VAL = TO_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
    localparam bit              TO_EN      = (TIMEOUT > 0);

    logic [TO_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable && (cnt != {TO_W{1'b1}})) begin
            cnt <= cnt + TO_W'(1);
        end
    end

    // Comparing against TIMEOUT-1 makes the flush land on the TIMEOUT-th idle cycle.
    assign expired = TO_EN && (cnt == EXPIRE_VAL);

endmodule

// File: rtl/fifo_nibble_packer.sv
// fifo_nibble_packer: drains 4-bit nibbles from a first-word-fall-through
// FIFO read port and packs nibble pairs into bytes on a valid/ready stream.
// A lone trailing nibble is zero-padded and emitted on flush or idle timeout.
// Ports:
//   clk, rst              - read-domain clock, async active-low reset
//   rempty, rdata, rinc   - FIFO read port (rinc is combinational)
//   flush                 - emit a held partial nibble
//   out_data, out_valid, out_ready, out_partial - output byte stream
//   byte_cnt              - completed output handshakes (wrapping)
//
// state    | meaning
// ---------+------------------------------------------
// ST_EMPTY | nothing held
// ST_HALF  | one nibble held, waiting for its partner
// ST_BYTE  | output register full, out_valid=1
module fifo_nibble_packer
    import fifo_nibble_packer_pkg::*;
#(
    parameter bit          LSN_FIRST = 1'b1,
    parameter int unsigned TIMEOUT   = 0,
    parameter int unsigned TO_W      = 8,
    parameter int unsigned CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rempty,
    input  logic [NIB_W-1:0]  rdata,
    output logic              rinc,
    input  logic              flush,
    output logic [BYTE_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_partial,
    output logic [CNT_W-1:0]  byte_cnt
);

    state_t             state, state_next;
    logic [NIB_W-1:0]   held, held_next;
    logic [BYTE_W-1:0]  data_next;
    logic               partial_next;
    logic               accept;
    logic               handshake;
    logic               to_clear, to_enable, to_expired;

    assign accept    = (state != ST_BYTE) || out_ready;
    // rst gates the strobe so the FIFO sees no pop while both sides are in reset.
    assign rinc      = !rempty && accept && rst;
    assign out_valid = (state == ST_BYTE);
    assign handshake = (state == ST_BYTE) && out_ready;

    always_comb begin
        state_next   = state;
        held_next    = held;
        data_next    = out_data;
        partial_next = out_partial;
        case (state)
            ST_EMPTY: begin
                if (rinc) begin
                    held_next  = rdata;
                    state_next = ST_HALF;
                end
            end
            ST_HALF: begin
                // A pop beats a same-cycle flush: the byte completes normally.
                if (rinc) begin
                    data_next    = pack_nibbles(held, rdata, LSN_FIRST);
                    partial_next = 1'b0;
                    state_next   = ST_BYTE;
                end else if (flush || to_expired) begin
                    data_next    = pack_nibbles(held, {NIB_W{1'b0}}, LSN_FIRST);
                    partial_next = 1'b1;
                    state_next   = ST_BYTE;
                end
            end
            ST_BYTE: begin
                if (out_ready) begin
                    if (rinc) begin
                        held_next  = rdata;
                        state_next = ST_HALF;
                    end else begin
                        state_next = ST_EMPTY;
                    end
                end
            end
            default: state_next = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_EMPTY;
            held        <= '0;
            out_data    <= '0;
            out_partial <= 1'b0;
        end else begin
            state       <= state_next;
            held        <= held_next;
            out_data    <= data_next;
            out_partial <= partial_next;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            byte_cnt <= '0;
        end else if (handshake) begin
            byte_cnt <= byte_cnt + CNT_W'(1);
        end
    end

    // In HALF an idle cycle is exactly rempty=1, since accept is always true there.
    assign to_clear  = (state_next != state) || (state != ST_HALF);
    assign to_enable = (state == ST_HALF) && rempty;

    nibble_timeout_ctr #(
        .TIMEOUT (TIMEOUT),
        .TO_W    (TO_W)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clear   (to_clear),
        .enable  (to_enable),
        .expired (to_expired)
    );

endmodule

// File: tb/tb_fifo_nibble_packer.sv
module tb_fifo_nibble_packer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       flush = 1'b0;
    logic       out_ready = 1'b0;
    logic       rempty [2];
    logic [3:0] rdata [2];
    logic       rinc [2];
    logic [7:0] out_data [2];
    logic       out_valid [2];
    logic       out_partial [2];
    logic [3:0]  bc0;
    logic [15:0] bc1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Instance 0: LSN first, 4-cycle timeout, narrow counter to exercise wrap.
    fifo_nibble_packer #(.LSN_FIRST(1'b1), .TIMEOUT(4), .TO_W(8), .CNT_W(4)) u_dut0 (
        .clk(clk), .rst(rst), .rempty(rempty[0]), .rdata(rdata[0]), .rinc(rinc[0]),
        .flush(flush), .out_data(out_data[0]), .out_valid(out_valid[0]),
        .out_ready(out_ready), .out_partial(out_partial[0]), .byte_cnt(bc0));

    // Instance 1: MSN first, no timeout, default counter width.
    fifo_nibble_packer #(.LSN_FIRST(1'b0), .TIMEOUT(0), .TO_W(8), .CNT_W(16)) u_dut1 (
        .clk(clk), .rst(rst), .rempty(rempty[1]), .rdata(rdata[1]), .rinc(rinc[1]),
        .flush(flush), .out_data(out_data[1]), .out_valid(out_valid[1]),
        .out_ready(out_ready), .out_partial(out_partial[1]), .byte_cnt(bc1));

    // FIFO contents per instance.
    logic [3:0] q0 [$];
    logic [3:0] q1 [$];

    // Reference model: what each packer holds, in plain terms.
    bit         m_have [2];
    logic [3:0] m_nib  [2];
    bit         m_full [2];
    logic [7:0] m_byte [2];
    bit         m_part [2];
    int         m_cnt  [2];
    int         m_idle [2];
    bit         lsn    [2] = '{1'b1, 1'b0};
    int         tmo    [2] = '{4, 0};
    int         cmask  [2] = '{15, 65535};

    logic [7:0] last_hs   [2];
    bit         last_part [2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int qsize(input int i);
        return (i == 0) ? q0.size() : q1.size();
    endfunction

    function automatic logic [3:0] qhead(input int i);
        if (i == 0) return q0[0];
        return q1[0];
    endfunction

    task automatic push(input logic [3:0] n);
        q0.push_back(n);
        q1.push_back(n);
    endtask

    task automatic drive_fifo();
        for (int i = 0; i < 2; i++) begin
            rempty[i] = (qsize(i) == 0);
            rdata[i]  = (qsize(i) == 0) ? 4'($urandom) : qhead(i);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_have[i] = 0; m_nib[i] = '0; m_full[i] = 0; m_byte[i] = '0;
            m_part[i] = 0; m_cnt[i] = 0; m_idle[i] = 0;
        end
    endtask

    // One clock cycle: drive, check, clock edge, advance model and FIFO.
    task automatic step(input bit fl, input bit rdy);
        bit         exp_rinc [2];
        bit         pop_d [2];
        bit         hs_d [2];
        logic [7:0] dat_d [2];
        bit         part_d [2];
        logic [3:0] head [2];
        flush     = fl;
        out_ready = rdy;
        drive_fifo();
        #1;
        for (int i = 0; i < 2; i++) begin
            exp_rinc[i] = (qsize(i) > 0) && (!m_full[i] || rdy);
            head[i]     = (qsize(i) > 0) ? qhead(i) : 4'h0;
            chk($sformatf("rinc%0d", i), 32'(rinc[i]), 32'(exp_rinc[i]));
            chk($sformatf("valid%0d", i), 32'(out_valid[i]), 32'(m_full[i]));
            if (m_full[i]) begin
                chk($sformatf("data%0d", i), 32'(out_data[i]), 32'(m_byte[i]));
                chk($sformatf("partial%0d", i), 32'(out_partial[i]), 32'(m_part[i]));
            end
            pop_d[i]  = rinc[i];
            hs_d[i]   = out_valid[i] && rdy;
            dat_d[i]  = out_data[i];
            part_d[i] = out_partial[i];
        end
        chk("byte_cnt0", 32'(bc0), 32'(m_cnt[0] & cmask[0]));
        chk("byte_cnt1", 32'(bc1), 32'(m_cnt[1] & cmask[1]));
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            if (m_full[i]) begin
                if (rdy) begin
                    m_cnt[i]++;
                    m_full[i] = 0;
                    if (exp_rinc[i]) begin m_have[i] = 1; m_nib[i] = head[i]; end
                end
                m_idle[i] = 0;
            end else if (m_have[i]) begin
                if (exp_rinc[i]) begin
                    m_byte[i] = lsn[i] ? {head[i], m_nib[i]} : {m_nib[i], head[i]};
                    m_part[i] = 0; m_full[i] = 1; m_have[i] = 0; m_idle[i] = 0;
                end else if (fl || (tmo[i] > 0 && m_idle[i] + 1 == tmo[i])) begin
                    m_byte[i] = lsn[i] ? {4'h0, m_nib[i]} : {m_nib[i], 4'h0};
                    m_part[i] = 1; m_full[i] = 1; m_have[i] = 0; m_idle[i] = 0;
                end else begin
                    m_idle[i]++;
                end
            end else begin
                if (exp_rinc[i]) begin m_have[i] = 1; m_nib[i] = head[i]; end
                m_idle[i] = 0;
            end
            if (hs_d[i]) begin last_hs[i] = dat_d[i]; last_part[i] = part_d[i]; end
        end
        if (pop_d[0] && q0.size() > 0) void'(q0.pop_front());
        if (pop_d[1] && q1.size() > 0) void'(q1.pop_front());
        @(negedge clk);
    endtask

    // Assert reset mid-cycle and check that everything clears at once.
    task automatic reset_check(input string tag);
        flush = 1'b0;
        out_ready = 1'b1;
        drive_fifo();
        #2 rst = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("%s_rinc%0d", tag, i), 32'(rinc[i]), 32'd0);
            chk($sformatf("%s_valid%0d", tag, i), 32'(out_valid[i]), 32'd0);
            chk($sformatf("%s_data%0d", tag, i), 32'(out_data[i]), 32'd0);
            chk($sformatf("%s_partial%0d", tag, i), 32'(out_partial[i]), 32'd0);
        end
        chk({tag, "_cnt0"}, 32'(bc0), 32'd0);
        chk({tag, "_cnt1"}, 32'(bc1), 32'd0);
        model_reset();
        q0.delete();
        q1.delete();
        @(negedge clk);
        drive_fifo();
        rst = 1'b1;
    endtask

    initial begin
        model_reset();
        last_hs = '{8'h00, 8'h00};
        last_part = '{1'b0, 1'b0};
        drive_fifo();
        @(negedge clk);
        @(negedge clk);
        push(4'h5);
        reset_check("por");

        // Two nibbles 3, A into one byte.
        push(4'h3); push(4'hA);
        repeat (4) step(0, 1);
        chk("first_byte0", 32'(last_hs[0]), 32'h A3);
        chk("first_byte1", 32'(last_hs[1]), 32'h 3A);
        chk("first_cnt0", 32'(bc0), 32'd1);

        // Continuous stream.
        for (int n = 1; n <= 6; n++) push(4'(n));
        repeat (8) step(0, 1);
        chk("stream_last0", 32'(last_hs[0]), 32'h65);
        chk("stream_last1", 32'(last_hs[1]), 32'h56);
        chk("stream_cnt1", 32'(bc1), 32'd4);

        // Backpressure, then handshake + pop on the same edge, then flush.
        push(4'h1); push(4'h2); push(4'h3);
        repeat (2) step(0, 1);
        repeat (5) step(0, 0);
        step(0, 1);
        chk("bp_byte0", 32'(last_hs[0]), 32'h21);
        chk("bp_q_empty", 32'(q0.size()), 32'd0);
        step(1, 1);
        step(0, 1);
        chk("bp_flush0", 32'(last_hs[0]), 32'h03);
        chk("bp_flush1", 32'(last_hs[1]), 32'h30);

        // Single nibble flushed.
        push(4'h7);
        step(0, 1); step(1, 1); step(0, 1);
        chk("flush_byte0", 32'(last_hs[0]), 32'h07);
        chk("flush_byte1", 32'(last_hs[1]), 32'h70);
        chk("flush_part0", 32'(last_part[0]), 32'd1);

        // Timeout on the 4th idle cycle (instance 0 only).
        push(4'h9);
        step(0, 1);
        repeat (3) step(0, 1);
        chk("to_not_yet0", 32'(out_valid[0]), 32'd0);
        step(0, 1);
        step(0, 1);
        chk("to_byte0", 32'(last_hs[0]), 32'h09);
        chk("to_part0", 32'(last_part[0]), 32'd1);
        chk("to_hold1", 32'(out_valid[1]), 32'd0);
        step(1, 1); step(0, 1);
        chk("to_flush1", 32'(last_hs[1]), 32'h90);

        // Nibble arrives on idle cycle 3: full byte instead of timeout.
        push(4'h9);
        step(0, 1);
        repeat (2) step(0, 1);
        push(4'h5);
        step(0, 1); step(0, 1);
        chk("to_cancel0", 32'(last_hs[0]), 32'h59);
        chk("to_cancel_part0", 32'(last_part[0]), 32'd0);
        chk("to_cancel1", 32'(last_hs[1]), 32'h95);

        // Pop and flush together in HALF.
        push(4'h2); push(4'h4);
        step(0, 1); step(1, 1); step(0, 1);
        chk("popflush0", 32'(last_hs[0]), 32'h42);
        chk("popflush_part0", 32'(last_part[0]), 32'd0);

        // Reset while HALF, then while BYTE.
        push(4'h8);
        step(0, 1);
        reset_check("rst_half");
        push(4'h1); push(4'h2); push(4'h3);
        step(0, 1); step(0, 1);
        reset_check("rst_byte");

        // Randomized traffic; also carries the 4-bit counter through wrap.
        for (int c = 0; c < 600; c++) begin
            if (q0.size() < 6 && q1.size() < 6 && $urandom_range(0, 1) == 1)
                push(4'($urandom));
            step(($urandom_range(0, 7) == 0), ($urandom_range(0, 3) != 0));
        end
        chk("rand_wrapped", 32'(m_cnt[0] > 16), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fifo_nibble_packer.md
Name: fifo_nibble_packer

Overview:
Read-side consumer of the 4-bit asynchronous CDC FIFO, running entirely in the read clock domain. Drains nibbles from the FIFO read port (rempty/rinc/rdata) and packs nibble pairs into 8-bit bytes on a valid/ready output stream. A partial trailing nibble can be flushed explicitly or by an idle timeout, padded with zeros.

Parameters:
LSN_FIRST, 1, 1: first popped nibble goes to out_data[3:0]; 0: first popped nibble goes to out_data[7:4].
TIMEOUT, 0, idle cycles in HALF before auto-flush; 0 disables auto-flush.
TO_W, 8, timeout counter width; TIMEOUT must be below 2^TO_W.
CNT_W, 16, width of byte_cnt.

Ports:
clk  input  1  read-domain clock (same clock as the FIFO read side); all logic on its rising edge.
rst  input  1  reset; asynchronous assert, active-low.
rempty  input  1  FIFO empty flag.
rdata  input  4  FIFO head nibble, valid whenever rempty=0 (first-word-fall-through).
rinc  output  1  pop strobe to FIFO, combinational.
flush  input  1  request to emit a held partial nibble; single-cycle pulse or level.
out_data  output  8  packed byte.
out_valid  output  1  out_data valid.
out_ready  input  1  downstream accepts when out_valid=1 and out_ready=1 on the same edge.
out_partial  output  1  qualifies out_data: byte is a zero-padded single nibble.
byte_cnt  output  CNT_W  count of output handshakes completed.

Behaviour:
- Reset (rst=0, async): state=EMPTY, out_valid=0, out_data=0, out_partial=0, byte_cnt=0, timeout counter=0, held nibble=0. rinc=0 while rst=0.
- States: EMPTY (nothing held), HALF (one nibble held), BYTE (output register full, out_valid=1).
- accept = (state!=BYTE) or out_ready. rinc = !rempty and accept and rst. Pop happens on the edge where rinc=1.
- EMPTY: pop -> latch rdata as first nibble, go HALF.
- HALF, pop -> out_data = {rdata, held} if LSN_FIRST=1, else {held, rdata}; out_partial=0; go BYTE. out_valid rises on the edge after the second pop (one cycle latency).
- HALF, no pop, and (flush=1 or timeout expired) -> out_data = {4'h0, held} if LSN_FIRST=1, else {held, 4'h0}; out_partial=1; go BYTE.
- HALF, pop and flush on the same cycle: the pop wins; the byte completes normally and the flush is dropped.
- flush in EMPTY or BYTE is ignored and not remembered.
- BYTE, out_ready=1: handshake completes, byte_cnt increments (wraps mod 2^CNT_W). With a simultaneous pop, latch the new first nibble and go HALF; otherwise go EMPTY and out_valid=0.
- BYTE, out_ready=0: out_data, out_partial and out_valid hold stable; rinc=0.
- Throughput: 1 byte per 2 cycles when the FIFO never empties and out_ready=1.
- Timeout counter: cleared on any state change, and every cycle state!=HALF. Increments each HALF cycle with rempty=1, saturating. Expiry means counter == TIMEOUT-1 with TIMEOUT>0, so the auto-flush takes effect on the TIMEOUT-th idle cycle.
- Reset mid-operation drops any held nibble and output byte immediately. Nibbles already popped are lost; the FIFO pointers are reset by the same rst.
- rdata is sampled only on pop edges; its value while rempty=1 is don't-care.

Decomposition:
- Shared package/header (the existing parameters header): state encodings ST_EMPTY=2'd0, ST_HALF=2'd1, ST_BYTE=2'd2; NIB_W=4, BYTE_W=8.
- One natural sub-module: nibble_timeout_ctr, the saturating idle counter with clear/enable/expire. Everything else lives flat in fifo_nibble_packer.

Test Plan:
- Reset release, FIFO holds 3,A, out_ready=1, LSN_FIRST=1 -> two rinc pulses, out_data=8'hA3, out_valid for one cycle, out_partial=0, byte_cnt=1, state returns to EMPTY.
- Continuous stream 1,2,3,4,5,6 with out_ready=1 -> bytes 8'h21, 8'h43, 8'h65 on alternate cycles, rinc high every cycle, byte_cnt=3.
- Backpressure: byte 8'h21 pending, out_ready=0 for 5 cycles, FIFO non-empty -> rinc=0 and out_data stable for 5 cycles. On out_ready=1, the handshake and the pop of the next nibble occur on the same edge.
- Single nibble 7 then rempty=1, flush pulse -> out_data=8'h07, out_partial=1. With LSN_FIRST=0 the same stimulus gives out_data=8'h70.
- TIMEOUT=4, single nibble 9 then empty, no flush -> partial byte 8'h09 emitted on the 4th idle cycle. If a nibble arrives on idle cycle 3, the counter clears and a full byte is emitted instead.
- Edge cases: pop and flush together in HALF -> full byte, out_partial=0. Reset asserted in HALF and BYTE -> all outputs 0 immediately. byte_cnt at 16'hFFFF plus one handshake -> 16'h0000.
